// File: rtl/sc_level_scheduler.sv
// Game-speed controller: paces LOAD pulses, advances the level and selects the speed band.
// Optional pause support is enabled by defining SC_LEVELSCHED_PAUSE_EN.
module sc_level_scheduler #(
  parameter int PERIOD_1        = 17500000,
  parameter int PERIOD_2        = 15000000,
  parameter int PERIOD_3        = 12500000,
  parameter int LOADS_PER_LEVEL = 16,
  parameter int BAND1_MAX       = 10,
  parameter int BAND2_MAX       = 32,
  parameter int LEVEL_MAX       = 59
) (
  input  logic       SC_LEVELSCHED_CLOCK_50,
  input  logic       SC_LEVELSCHED_RESET_InLow,
  input  logic       SC_LEVELSCHED_START_InLow,
  input  logic       SC_LEVELSCHED_COLLISION_InHigh,
`ifdef SC_LEVELSCHED_PAUSE_EN
  input  logic       SC_LEVELSCHED_PAUSE_InHigh,
`endif
  output logic       SC_LEVELSCHED_LOAD_OutHigh,
  output logic [7:0] SC_LEVELSCHED_LEVEL,
  output logic [1:0] SC_LEVELSCHED_MUXSEL,
  output logic       SC_LEVELSCHED_RUNNING_OutHigh,
  output logic       SC_LEVELSCHED_GAMEOVER_OutHigh
);

  localparam int LCW = $clog2(LOADS_PER_LEVEL + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_GAMEOVER} state_t;

  state_t         state_q, state_d;
  logic [24:0]    tick_q, tick_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [7:0]     level_q, level_d;
  logic           load_q, load_d;
  logic           running_q, running_d;
  logic           gameover_q, gameover_d;
  logic           start_s_q, start_s_d;
  logic           start_prev_q, start_prev_d;

  logic           start_ev;
  logic [1:0]     band;
  logic [24:0]    period_m1;

  always_comb begin
    if (level_q <= 8'(BAND1_MAX))      band = 2'd0;
    else if (level_q <= 8'(BAND2_MAX)) band = 2'd1;
    else                               band = 2'd2;
  end

  always_comb begin
    case (band)
      2'd0:    period_m1 = 25'(PERIOD_1 - 1);
      2'd1:    period_m1 = 25'(PERIOD_2 - 1);
      default: period_m1 = 25'(PERIOD_3 - 1);
    endcase
  end

  // Falling edge of the registered start sample; holding the button yields one event.
  assign start_ev = !start_s_q && start_prev_q;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    lcnt_d       = lcnt_q;
    level_d      = level_q;
    load_d       = 1'b0;
    start_s_d    = SC_LEVELSCHED_START_InLow;
    start_prev_d = start_s_q;
    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start_ev) begin
          state_d = S_RUN;
          tick_d  = '0;
          lcnt_d  = '0;
          level_d = '0;
        end
      end
      S_RUN: begin
        // Collision outranks the terminal tick: counters freeze and no LOAD is issued.
        if (SC_LEVELSCHED_COLLISION_InHigh) begin
          state_d = S_GAMEOVER;
`ifdef SC_LEVELSCHED_PAUSE_EN
        end else if (SC_LEVELSCHED_PAUSE_InHigh) begin
          state_d = S_PAUSE;
`endif
        end else if (tick_q == period_m1) begin
          tick_d = '0;
          load_d = 1'b1;
          if (lcnt_q == LCW'(LOADS_PER_LEVEL - 1)) begin
            lcnt_d = '0;
            if (level_q < 8'(LEVEL_MAX)) level_d = level_q + 8'd1;
          end else begin
            lcnt_d = lcnt_q + LCW'(1);
          end
        end else begin
          tick_d = tick_q + 25'd1;
        end
      end
`ifdef SC_LEVELSCHED_PAUSE_EN
      S_PAUSE: begin
        if (!SC_LEVELSCHED_PAUSE_InHigh) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    running_d  = (state_d == S_RUN);
    gameover_d = (state_d == S_GAMEOVER);
  end

  always_ff @(posedge SC_LEVELSCHED_CLOCK_50 or negedge SC_LEVELSCHED_RESET_InLow) begin
    if (!SC_LEVELSCHED_RESET_InLow) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      lcnt_q       <= '0;
      level_q      <= '0;
      load_q       <= 1'b0;
      running_q    <= 1'b0;
      gameover_q   <= 1'b0;
      start_s_q    <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      lcnt_q       <= lcnt_d;
      level_q      <= level_d;
      load_q       <= load_d;
      running_q    <= running_d;
      gameover_q   <= gameover_d;
      start_s_q    <= start_s_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign SC_LEVELSCHED_LOAD_OutHigh     = load_q;
  assign SC_LEVELSCHED_LEVEL            = level_q;
  assign SC_LEVELSCHED_MUXSEL           = band;
  assign SC_LEVELSCHED_RUNNING_OutHigh  = running_q;
  assign SC_LEVELSCHED_GAMEOVER_OutHigh = gameover_q;

endmodule

// File: tb/tb_sc_level_scheduler.sv
// Bench for sc_level_scheduler: directed table, corner sequences and random run vs a load-count model.
module tb_sc_level_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1;
  logic       coll = 1'b0;
  logic       load_o;
  logic [7:0] level_o;
  logic [1:0] mux_o;
  logic       run_o;
  logic       go_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_level_scheduler #(
    .PERIOD_1(8), .PERIOD_2(6), .PERIOD_3(4), .LOADS_PER_LEVEL(2),
    .BAND1_MAX(1), .BAND2_MAX(3), .LEVEL_MAX(5)
  ) dut (
    .SC_LEVELSCHED_CLOCK_50(clk),
    .SC_LEVELSCHED_RESET_InLow(rst_n),
    .SC_LEVELSCHED_START_InLow(start_n),
    .SC_LEVELSCHED_COLLISION_InHigh(coll),
`ifdef SC_LEVELSCHED_PAUSE_EN
    .SC_LEVELSCHED_PAUSE_InHigh(1'b0),
`endif
    .SC_LEVELSCHED_LOAD_OutHigh(load_o),
    .SC_LEVELSCHED_LEVEL(level_o),
    .SC_LEVELSCHED_MUXSEL(mux_o),
    .SC_LEVELSCHED_RUNNING_OutHigh(run_o),
    .SC_LEVELSCHED_GAMEOVER_OutHigh(go_o)
  );

  // Reference model: the level is derived from the total LOAD count since the game began.
  int m_mode;      // 0 idle, 1 running, 2 game over
  int m_nloads;
  int m_elapsed;
  bit m_p1, m_p2;
  bit m_load;

  function automatic int m_level();
    int lv = m_nloads / 2;
    return (lv > 5) ? 5 : lv;
  endfunction

  function automatic int band_of(int lv);
    if (lv <= 1) return 0;
    if (lv <= 3) return 1;
    return 2;
  endfunction

  function automatic int period_of(int b);
    if (b == 0) return 8;
    if (b == 1) return 6;
    return 4;
  endfunction

  function automatic logic [12:0] pk(logic l, int lv, int mx, logic r, logic g);
    return {l, 8'(lv), 2'(mx), r, g};
  endfunction

  function automatic logic [12:0] model_out();
    return pk(m_load, m_level(), band_of(m_level()), m_mode == 1, m_mode == 2);
  endfunction

  function automatic logic [12:0] dut_out();
    return {load_o, level_o, mux_o, run_o, go_o};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_nloads = 0; m_elapsed = 0; m_p1 = 1; m_p2 = 1; m_load = 0;
  endtask

  task automatic model_edge(bit s, bit c);
    bit ev;
    ev = (m_p1 == 0) && (m_p2 == 1);
    m_load = 0;
    case (m_mode)
      1: begin
        if (c) m_mode = 2;
        else begin
          m_elapsed++;
          if (m_elapsed == period_of(band_of(m_level()))) begin
            m_load = 1; m_nloads++; m_elapsed = 0;
          end
        end
      end
      default: if (ev) begin m_mode = 1; m_nloads = 0; m_elapsed = 0; end
    endcase
    m_p2 = m_p1;
    m_p1 = s;
  endtask

  task automatic check(string name, logic [12:0] got, logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h (load,level,mux,run,go) required %h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(start_n, coll);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_n = 1'b1; coll = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("in_reset", dut_out(), pk(0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_load(int budget, output int cyc);
    bit found = 0;
    cyc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      cyc++;
      if (load_o) found = 1;
    end
    check("load_timeout", {12'd0, found}, 13'd1);
  endtask

  typedef struct {
    logic        start;
    logic        coll;
    int          ncyc;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cyc;
    int rises;
    bit prev_run;
    bit hit;

    tbl[0]  = '{1'b1, 1'b0, 2, pk(0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 1, pk(0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 1, pk(0, 0, 0, 1, 0)};
    tbl[3]  = '{1'b0, 1'b0, 7, pk(0, 0, 0, 1, 0)};
    tbl[4]  = '{1'b0, 1'b0, 1, pk(1, 0, 0, 1, 0)};
    tbl[5]  = '{1'b0, 1'b0, 7, pk(0, 0, 0, 1, 0)};
    tbl[6]  = '{1'b0, 1'b0, 1, pk(1, 1, 0, 1, 0)};
    tbl[7]  = '{1'b1, 1'b0, 7, pk(0, 1, 0, 1, 0)};
    tbl[8]  = '{1'b1, 1'b0, 1, pk(1, 1, 0, 1, 0)};
    tbl[9]  = '{1'b1, 1'b0, 7, pk(0, 1, 0, 1, 0)};
    tbl[10] = '{1'b1, 1'b0, 1, pk(1, 2, 1, 1, 0)};
    tbl[11] = '{1'b1, 1'b0, 5, pk(0, 2, 1, 1, 0)};
    tbl[12] = '{1'b1, 1'b0, 1, pk(1, 2, 1, 1, 0)};
    tbl[13] = '{1'b0, 1'b0, 5, pk(0, 2, 1, 1, 0)};
    tbl[14] = '{1'b0, 1'b0, 1, pk(1, 3, 1, 1, 0)};

    do_reset();
    for (int r = 0; r < 15; r++) begin
      start_n = tbl[r].start;
      coll    = tbl[r].coll;
      for (int k = 0; k < tbl[r].ncyc; k++) begin
        step();
        check($sformatf("table_row%0d", r), dut_out(), tbl[r].exp);
      end
    end

    // Climb to the top level, then confirm saturation with a 4-cycle period.
    start_n = 1'b1;
    for (int i = 0; i < 5; i++) wait_load(20, cyc);
    check("sat_level", {3'd0, level_o, mux_o}, {3'd0, 8'd5, 2'd2});
    wait_load(20, cyc);
    check("sat_period", 13'(cyc), 13'd4);
    wait_load(20, cyc);
    check("sat_period2", 13'(cyc), 13'd4);
    check("sat_hold", {3'd0, level_o, mux_o}, {3'd0, 8'd5, 2'd2});

    // Collision coinciding with the terminal tick.
    repeat (3) step();
    coll = 1'b1;
    step();
    check("coll_terminal", dut_out(), pk(0, 5, 2, 0, 1));
    coll = 1'b0;
    repeat (4) step();
    check("gameover_hold", dut_out(), pk(0, 5, 2, 0, 1));
    start_n = 1'b0;
    step();
    step();
    check("restart", dut_out(), pk(0, 0, 0, 1, 0));
    start_n = 1'b1;
    wait_load(20, cyc);
    check("restart_first_load", 13'(cyc), 13'd8);

    // Start held low in idle: exactly one transition into RUN.
    do_reset();
    start_n = 1'b0;
    rises = 0;
    prev_run = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (run_o && !prev_run) rises++;
      prev_run = run_o;
    end
    check("held_start_rises", 13'(rises), 13'd1);
    check("held_start_running", {12'd0, run_o}, 13'd1);
    start_n = 1'b1;

    // Asynchronous reset in the middle of a period at level 3.
    do_reset();
    start_n = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (m_level() == 3) hit = 1;
    end
    check("reach_level3", {3'd0, level_o, mux_o}, {3'd0, 8'd3, 2'd1});
    step();
    step();
    #3 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), pk(0, 0, 0, 0, 0));
    model_reset();
    start_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    check("idle_after_reset", dut_out(), pk(0, 0, 0, 0, 0));

    // Random start/collision traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      start_n = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      coll    = ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
